// File: rtl/preg_freelist_ctrl_pkg.sv
// Shared sizing defaults and request encoding for the physical-register free list.
package preg_freelist_ctrl_pkg;

    localparam int DEF_NUM_PREGS         = 64;
    localparam int DEF_NUM_AREGS         = 16;
    localparam int DEF_MAX_PREDICT_DEPTH = 4;

    typedef enum logic [1:0] {
        ALLOC_NONE = 2'd0,
        ALLOC_ONE  = 2'd1,
        ALLOC_TWO  = 2'd2
    } alloc_req_e;

    // True when the free list holds enough entries to cover the request.
    function automatic logic count_covers(input logic [1:0] req, input logic has1, input logic has2);
        if (req == ALLOC_NONE) return 1'b1;
        if (req == ALLOC_ONE)  return has1;
        return has2;
    endfunction

endpackage

// File: rtl/preg_freelist_ctrl_pick_two_free.sv
// Lowest-two-set-bit encoder over the free map; idx1 < idx2 whenever has2 is set.
module pick_two_free #(
    parameter int N = 64,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] free_map,
    output logic [W-1:0] idx1,
    output logic [W-1:0] idx2,
    output logic         has1,
    output logic         has2
);

    logic [N-1:0] rest;

    always_comb begin
        idx1 = '0;
        has1 = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (free_map[i]) begin
                idx1 = W'(i);
                has1 = 1'b1;
            end
        end
        rest       = free_map;
        rest[idx1] = 1'b0;
        idx2 = '0;
        has2 = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rest[i]) begin
                idx2 = W'(i);
                has2 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/preg_freelist_ctrl.sv
// Physical-register free list: two grants and two releases per cycle, with branch
// checkpoint shootdown built only when FREELIST_CHECKPOINT_EN is defined.
module preg_freelist_ctrl
    import preg_freelist_ctrl_pkg::*;
#(
    parameter int NUM_PREGS              = DEF_NUM_PREGS,
    parameter int NUM_AREGS              = DEF_NUM_AREGS,
    parameter int MAX_PREDICT_DEPTH      = DEF_MAX_PREDICT_DEPTH,
    parameter int MAX_PREDICT_DEPTH_BITS = $clog2(MAX_PREDICT_DEPTH),
    localparam int P = $clog2(NUM_PREGS),
    localparam int T = MAX_PREDICT_DEPTH_BITS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   alloc_num,
    output logic         alloc_ok,
    output logic [P-1:0] preg1,
    output logic [P-1:0] preg2,
    input  logic         free1,
    input  logic         free2,
    input  logic [P-1:0] free1_addr,
    input  logic [P-1:0] free2_addr,
    input  logic         ckpt_open,
    input  logic [T-1:0] ckpt_tag,
    input  logic         ckpt_close,
    input  logic [T-1:0] close_tag,
    input  logic         branch_shootdown,
    input  logic [T-1:0] shootdown_branch_tag,
    output logic [P:0]   num_free,
    output logic         ckpt_full
);

    localparam logic [NUM_PREGS-1:0] FREE_RST = {NUM_PREGS{1'b1}} << NUM_AREGS;

    logic [NUM_PREGS-1:0] free_map, free_map_nxt;
    logic [NUM_PREGS-1:0] grant_mask, release_mask, shoot_mask;
    logic [P-1:0]         idx1, idx2;
    logic                 has1, has2;
    logic                 alloc_fire;

    pick_two_free #(.N(NUM_PREGS)) u_pick (
        .free_map (free_map),
        .idx1     (idx1),
        .idx2     (idx2),
        .has1     (has1),
        .has2     (has2)
    );

    assign preg1      = idx1;
    assign preg2      = idx2;
    assign alloc_ok   = !branch_shootdown && count_covers(alloc_num, has1, has2);
    assign alloc_fire = alloc_ok && (alloc_num != ALLOC_NONE);

    always_comb begin
        grant_mask = '0;
        if (alloc_fire) begin
            grant_mask[idx1] = 1'b1;
            if (alloc_num[1]) grant_mask[idx2] = 1'b1;
        end
        release_mask = '0;
        if (free1) release_mask[free1_addr] = 1'b1;
        if (free2) release_mask[free2_addr] = 1'b1;
        // Releases land at the edge, so a freed preg is never granted in its own cycle.
        free_map_nxt = (free_map & ~grant_mask) | release_mask | shoot_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            free_map <= FREE_RST;
            num_free <= (P + 1)'(NUM_PREGS - NUM_AREGS);
        end else begin
            free_map <= free_map_nxt;
            num_free <= (P + 1)'($countones(free_map_nxt));
        end
    end

    assert property (@(posedge clk) disable iff (reset) free1 |-> !free_map[free1_addr]);
    assert property (@(posedge clk) disable iff (reset) free2 |-> !free_map[free2_addr]);
    assert property (@(posedge clk) disable iff (reset) (free1 && free2) |-> (free1_addr != free2_addr));

`ifdef FREELIST_CHECKPOINT_EN
    logic [MAX_PREDICT_DEPTH-1:0] active, active_nxt, kill;
    logic [NUM_PREGS-1:0]         spec_mask [MAX_PREDICT_DEPTH];
    logic [MAX_PREDICT_DEPTH-1:0] older     [MAX_PREDICT_DEPTH];
    logic                         ckpt_full_r;
    logic                         open_fire;

    assign open_fire = ckpt_open && !branch_shootdown;

    always_comb begin
        kill       = '0;
        shoot_mask = '0;
        if (branch_shootdown) begin
            // Younger checkpoints that saw the mispredicted tag active die with it.
            for (int j = 0; j < MAX_PREDICT_DEPTH; j++)
                kill[j] = (T'(j) == shootdown_branch_tag) ||
                          (active[j] && older[j][shootdown_branch_tag]);
        end
        for (int j = 0; j < MAX_PREDICT_DEPTH; j++)
            if (kill[j]) shoot_mask = shoot_mask | spec_mask[j];
        active_nxt = active;
        if (ckpt_close && !kill[close_tag]) active_nxt[close_tag] = 1'b0;
        if (open_fire) active_nxt[ckpt_tag] = 1'b1;
        active_nxt = active_nxt & ~kill;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active      <= '0;
            ckpt_full_r <= 1'b0;
            for (int j = 0; j < MAX_PREDICT_DEPTH; j++) begin
                spec_mask[j] <= '0;
                older[j]     <= '0;
            end
        end else begin
            active      <= active_nxt;
            ckpt_full_r <= &active_nxt;
            for (int j = 0; j < MAX_PREDICT_DEPTH; j++) begin
                if (open_fire && (ckpt_tag == T'(j))) begin
                    spec_mask[j] <= '0;
                    older[j]     <= active;
                end else if (active[j]) begin
                    spec_mask[j] <= spec_mask[j] | grant_mask;
                end
            end
        end
    end

    assign ckpt_full = ckpt_full_r;

    assert property (@(posedge clk) disable iff (reset) open_fire |-> !active[ckpt_tag]);
`else
    logic unused_ckpt;

    assign shoot_mask  = '0;
    assign ckpt_full   = 1'b0;
    assign unused_ckpt = ^{ckpt_open, ckpt_tag, ckpt_close, close_tag, shootdown_branch_tag};
`endif

endmodule

// File: tb/tb_preg_freelist_ctrl.sv
// Directed bench for preg_freelist_ctrl; checkpoint scenarios run when FREELIST_CHECKPOINT_EN is defined.
`timescale 1ns/1ps
module tb_preg_freelist_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] alloc_num;
    logic       alloc_ok;
    logic [5:0] preg1, preg2;
    logic       free1, free2;
    logic [5:0] free1_addr, free2_addr;
    logic       ckpt_open, ckpt_close, branch_shootdown;
    logic [1:0] ckpt_tag, close_tag, shootdown_branch_tag;
    logic [6:0] num_free;
    logic       ckpt_full;

    int vectors = 0;
    int miscompares = 0;

    preg_freelist_ctrl dut (
        .clk                  (clk),
        .reset                (reset),
        .alloc_num            (alloc_num),
        .alloc_ok             (alloc_ok),
        .preg1                (preg1),
        .preg2                (preg2),
        .free1                (free1),
        .free2                (free2),
        .free1_addr           (free1_addr),
        .free2_addr           (free2_addr),
        .ckpt_open            (ckpt_open),
        .ckpt_tag             (ckpt_tag),
        .ckpt_close           (ckpt_close),
        .close_tag            (close_tag),
        .branch_shootdown     (branch_shootdown),
        .shootdown_branch_tag (shootdown_branch_tag),
        .num_free             (num_free),
        .ckpt_full            (ckpt_full)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        alloc_num = 2'd0; free1 = 1'b0; free2 = 1'b0; free1_addr = '0; free2_addr = '0;
        ckpt_open = 1'b0; ckpt_tag = '0; ckpt_close = 1'b0; close_tag = '0;
        branch_shootdown = 1'b0; shootdown_branch_tag = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic alloc_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            alloc_num = 2'd2;
            tick();
        end
        alloc_num = 2'd0;
    endtask

    task automatic test_reset();
        do_reset();
        alloc_num = 2'd2;
        #1;
        vectors++; if (num_free !== 7'd48) begin miscompares++; $display("FAIL reset_num_free: got %0d expected 48", num_free); end
        vectors++; if (alloc_ok !== 1'b1) begin miscompares++; $display("FAIL reset_alloc_ok: got %b expected 1", alloc_ok); end
        vectors++; if (preg1 !== 6'd16) begin miscompares++; $display("FAIL reset_preg1: got %0d expected 16", preg1); end
        vectors++; if (preg2 !== 6'd17) begin miscompares++; $display("FAIL reset_preg2: got %0d expected 17", preg2); end
        vectors++; if (ckpt_full !== 1'b0) begin miscompares++; $display("FAIL reset_ckpt_full: got %b expected 0", ckpt_full); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 24; i++) begin
            alloc_num = 2'd2;
            #1;
            vectors++; if (alloc_ok !== 1'b1) begin miscompares++; $display("FAIL drain_ok[%0d]: got %b expected 1", i, alloc_ok); end
            vectors++; if (preg1 !== 6'(16 + 2 * i)) begin miscompares++; $display("FAIL drain_preg1[%0d]: got %0d expected %0d", i, preg1, 16 + 2 * i); end
            vectors++; if (preg2 !== 6'(17 + 2 * i)) begin miscompares++; $display("FAIL drain_preg2[%0d]: got %0d expected %0d", i, preg2, 17 + 2 * i); end
            if (i == 12) begin
                vectors++; if (num_free !== 7'd24) begin miscompares++; $display("FAIL drain_half_num_free: got %0d expected 24", num_free); end
            end
            tick();
        end
        alloc_num = 2'd2;
        #1;
        vectors++; if (alloc_ok !== 1'b0) begin miscompares++; $display("FAIL empty_ok2: got %b expected 0", alloc_ok); end
        vectors++; if (num_free !== 7'd0) begin miscompares++; $display("FAIL empty_num_free: got %0d expected 0", num_free); end
        alloc_num = 2'd1;
        #1;
        vectors++; if (alloc_ok !== 1'b0) begin miscompares++; $display("FAIL empty_ok1: got %b expected 0", alloc_ok); end
        alloc_num = 2'd0;
        #1;
        vectors++; if (alloc_ok !== 1'b1) begin miscompares++; $display("FAIL empty_ok0: got %b expected 1", alloc_ok); end
        tick();
    endtask

    task automatic test_free_visibility();
        alloc_num = 2'd2;
        free1 = 1'b1; free1_addr = 6'd20;
        free2 = 1'b1; free2_addr = 6'd40;
        #1;
        vectors++; if (alloc_ok !== 1'b0) begin miscompares++; $display("FAIL free_same_cycle_ok: got %b expected 0", alloc_ok); end
        tick();
        free1 = 1'b0; free2 = 1'b0;
        #1;
        vectors++; if (alloc_ok !== 1'b1) begin miscompares++; $display("FAIL free_next_ok: got %b expected 1", alloc_ok); end
        vectors++; if (preg1 !== 6'd20) begin miscompares++; $display("FAIL free_next_preg1: got %0d expected 20", preg1); end
        vectors++; if (preg2 !== 6'd40) begin miscompares++; $display("FAIL free_next_preg2: got %0d expected 40", preg2); end
        vectors++; if (num_free !== 7'd2) begin miscompares++; $display("FAIL free_next_num_free: got %0d expected 2", num_free); end
        tick();
        alloc_num = 2'd1;
        #1;
        vectors++; if (num_free !== 7'd0) begin miscompares++; $display("FAIL free_after_num_free: got %0d expected 0", num_free); end
        vectors++; if (alloc_ok !== 1'b0) begin miscompares++; $display("FAIL free_after_ok: got %b expected 0", alloc_ok); end
        alloc_num = 2'd0;
        tick();
    endtask

    task automatic test_shootdown_with_alloc();
        free1 = 1'b1; free1_addr = 6'd30;
        free2 = 1'b1; free2_addr = 6'd31;
        tick();
        free2 = 1'b0;
        free1 = 1'b1; free1_addr = 6'd5;
        alloc_num = 2'd2;
        branch_shootdown = 1'b1; shootdown_branch_tag = 2'd0;
        #1;
        vectors++; if (alloc_ok !== 1'b0) begin miscompares++; $display("FAIL sd_alloc_ok: got %b expected 0", alloc_ok); end
        vectors++; if (num_free !== 7'd2) begin miscompares++; $display("FAIL sd_pre_num_free: got %0d expected 2", num_free); end
        tick();
        idle();
        alloc_num = 2'd2;
        #1;
        vectors++; if (num_free !== 7'd3) begin miscompares++; $display("FAIL sd_post_num_free: got %0d expected 3", num_free); end
        vectors++; if (alloc_ok !== 1'b1) begin miscompares++; $display("FAIL sd_post_ok: got %b expected 1", alloc_ok); end
        vectors++; if (preg1 !== 6'd5) begin miscompares++; $display("FAIL sd_post_preg1: got %0d expected 5", preg1); end
        vectors++; if (preg2 !== 6'd30) begin miscompares++; $display("FAIL sd_post_preg2: got %0d expected 30", preg2); end
        tick();
        alloc_num = 2'd1;
        #1;
        vectors++; if (preg1 !== 6'd31) begin miscompares++; $display("FAIL single_preg1: got %0d expected 31", preg1); end
        vectors++; if (num_free !== 7'd1) begin miscompares++; $display("FAIL single_num_free: got %0d expected 1", num_free); end
        tick();
        alloc_num = 2'd0;
        #1;
        vectors++; if (num_free !== 7'd0) begin miscompares++; $display("FAIL single_after_num_free: got %0d expected 0", num_free); end
        tick();
    endtask

    task automatic test_reset_mid();
        alloc_num = 2'd2;
        reset = 1'b1;
        #1;
        vectors++; if (num_free !== 7'd48) begin miscompares++; $display("FAIL async_reset_num_free: got %0d expected 48", num_free); end
        vectors++; if (preg1 !== 6'd16) begin miscompares++; $display("FAIL async_reset_preg1: got %0d expected 16", preg1); end
        vectors++; if (alloc_ok !== 1'b1) begin miscompares++; $display("FAIL async_reset_ok: got %b expected 1", alloc_ok); end
        reset = 1'b0;
        alloc_num = 2'd0;
        tick();
    endtask

`ifdef FREELIST_CHECKPOINT_EN
    task automatic test_nested_shootdown();
        do_reset();
        ckpt_open = 1'b1; ckpt_tag = 2'd1;
        tick();
        ckpt_open = 1'b0;
        alloc_cycles(9);
        #1;
        vectors++; if (num_free !== 7'd30) begin miscompares++; $display("FAIL nest_mid_num_free: got %0d expected 30", num_free); end
        ckpt_open = 1'b1; ckpt_tag = 2'd2;
        tick();
        ckpt_open = 1'b0;
        alloc_cycles(2);
        #1;
        vectors++; if (num_free !== 7'd26) begin miscompares++; $display("FAIL nest_pre_sd_num_free: got %0d expected 26", num_free); end
        branch_shootdown = 1'b1; shootdown_branch_tag = 2'd1;
        tick();
        idle();
        alloc_num = 2'd2;
        #1;
        vectors++; if (num_free !== 7'd48) begin miscompares++; $display("FAIL nest_sd_num_free: got %0d expected 48", num_free); end
        vectors++; if (preg1 !== 6'd16) begin miscompares++; $display("FAIL nest_sd_preg1: got %0d expected 16", preg1); end
        vectors++; if (preg2 !== 6'd17) begin miscompares++; $display("FAIL nest_sd_preg2: got %0d expected 17", preg2); end
        alloc_num = 2'd0;
        for (int t = 0; t < 4; t++) begin
            ckpt_open = 1'b1; ckpt_tag = 2'(t);
            #1;
            vectors++; if (ckpt_full !== 1'b0) begin miscompares++; $display("FAIL fill_ckpt_full[%0d]: got %b expected 0", t, ckpt_full); end
            tick();
        end
        ckpt_open = 1'b0;
        #1;
        vectors++; if (ckpt_full !== 1'b1) begin miscompares++; $display("FAIL full_ckpt_full: got %b expected 1", ckpt_full); end
        ckpt_close = 1'b1; close_tag = 2'd3;
        tick();
        ckpt_close = 1'b0;
        #1;
        vectors++; if (ckpt_full !== 1'b0) begin miscompares++; $display("FAIL close_ckpt_full: got %b expected 0", ckpt_full); end
        tick();
    endtask

    task automatic test_partial_shootdown();
        do_reset();
        ckpt_open = 1'b1; ckpt_tag = 2'd0;
        tick();
        ckpt_open = 1'b0;
        alloc_cycles(1);
        ckpt_open = 1'b1; ckpt_tag = 2'd3;
        tick();
        ckpt_open = 1'b0;
        alloc_cycles(1);
        #1;
        vectors++; if (num_free !== 7'd44) begin miscompares++; $display("FAIL part_pre_num_free: got %0d expected 44", num_free); end
        branch_shootdown = 1'b1; shootdown_branch_tag = 2'd3;
        tick();
        idle();
        alloc_num = 2'd2;
        #1;
        vectors++; if (num_free !== 7'd46) begin miscompares++; $display("FAIL part_sd_num_free: got %0d expected 46", num_free); end
        vectors++; if (preg1 !== 6'd18) begin miscompares++; $display("FAIL part_sd_preg1: got %0d expected 18", preg1); end
        vectors++; if (preg2 !== 6'd19) begin miscompares++; $display("FAIL part_sd_preg2: got %0d expected 19", preg2); end
        alloc_num = 2'd0;
        branch_shootdown = 1'b1; shootdown_branch_tag = 2'd0;
        tick();
        idle();
        #1;
        vectors++; if (num_free !== 7'd48) begin miscompares++; $display("FAIL part_outer_num_free: got %0d expected 48", num_free); end
        vectors++; if (preg1 !== 6'd16) begin miscompares++; $display("FAIL part_outer_preg1: got %0d expected 16", preg1); end
        tick();
    endtask
`else
    task automatic test_no_checkpoint();
        do_reset();
        alloc_cycles(2);
        for (int t = 0; t < 4; t++) begin
            ckpt_open = 1'b1; ckpt_tag = 2'(3 - t);
            tick();
        end
        ckpt_open = 1'b0;
        branch_shootdown = 1'b1; shootdown_branch_tag = 2'($urandom_range(0, 3));
        #1;
        vectors++; if (ckpt_full !== 1'b0) begin miscompares++; $display("FAIL nockpt_full: got %b expected 0", ckpt_full); end
        tick();
        idle();
        alloc_num = 2'd2;
        #1;
        vectors++; if (num_free !== 7'd44) begin miscompares++; $display("FAIL nockpt_num_free: got %0d expected 44", num_free); end
        vectors++; if (preg1 !== 6'd20) begin miscompares++; $display("FAIL nockpt_preg1: got %0d expected 20", preg1); end
        vectors++; if (preg2 !== 6'd21) begin miscompares++; $display("FAIL nockpt_preg2: got %0d expected 21", preg2); end
        alloc_num = 2'd0;
        tick();
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_drain();
        test_free_visibility();
        test_shootdown_with_alloc();
        test_reset_mid();
`ifdef FREELIST_CHECKPOINT_EN
        test_nested_shootdown();
        test_partial_shootdown();
`else
        test_no_checkpoint();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
